// File: rtl/pixie_dma_host.sv
// CDP1802-side bus sequencer for the Pixie display: steps machine cycles on SC,
// fetches DMA bytes from memory at R0 and reloads R0 from dma_base on interrupts.
module pixie_dma_host #(
  parameter int CYCLE_TICKS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        DMAO,
  input  logic        INT,
  input  logic        EFx,
  input  logic [15:0] dma_base,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [1:0]  SC,
  output logic [7:0]  data_out,
  output logic [15:0] r0,
  output logic        ie,
  output logic        ef_q,
  output logic [10:0] frame_bytes
);

  localparam int TW = (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(CYCLE_TICKS - 1);
  localparam logic [10:0]   BYTE_MAX  = 11'h7FF;

  typedef enum logic [1:0] {
    S0_FETCH = 2'b00,
    S1_EXEC  = 2'b01,
    S2_DMA   = 2'b10,
    S3_INT   = 2'b11
  } sc_t;

  sc_t           state, state_nxt;
  logic [TW-1:0] tick_cnt;
  logic [10:0]   byte_cnt;
  logic          tick_first, tick_second, cycle_end;

  // Every per-tick action is qualified by clk_enable so a stalled bus freezes in place.
  assign tick_first  = clk_enable && (tick_cnt == '0);
  assign tick_second = clk_enable && (tick_cnt == TW'(1));
  assign cycle_end   = clk_enable && (tick_cnt == LAST_TICK);

  assign SC       = state;
  assign mem_addr = r0;
  assign mem_rd   = (state == S2_DMA) && tick_first;

  // DMA is tested before interrupt in every branch, giving it priority.
  always_comb begin
    // NOTE: default assignment first so no path through the block can infer a latch.
    state_nxt = state;
    if (cycle_end) begin
      unique case (state)
        S0_FETCH: state_nxt = S1_EXEC;
        S1_EXEC,
        S2_DMA:   state_nxt = DMAO ? S2_DMA : ((INT && ie) ? S3_INT : S0_FETCH);
        S3_INT:   state_nxt = DMAO ? S2_DMA : S0_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
    if (reset) begin
      state    <= S0_FETCH;
      tick_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clk_enable) tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + TW'(1);
    end
  end

  // Reset mid-S2 simply drops the pending increment; nothing else needs unwinding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0          <= 16'h0000;
      ie          <= 1'b1;
      data_out    <= 8'h00;
      byte_cnt    <= 11'd0;
      frame_bytes <= 11'd0;
    end else begin
      unique case (state)
        S2_DMA: begin
          if (tick_second) data_out <= mem_data;
          if (cycle_end) begin
            r0 <= r0 + 16'd1;
            if (byte_cnt != BYTE_MAX) byte_cnt <= byte_cnt + 11'd1;
          end
        end
        S3_INT: begin
          if (tick_first) ie <= 1'b0;
          if (cycle_end) begin
            r0          <= dma_base;
            frame_bytes <= byte_cnt;
            byte_cnt    <= 11'd0;
          end
        end
        S0_FETCH,
        S1_EXEC: begin
          // Re-arm only once INT has been seen low, so one assertion yields one S3.
          if (cycle_end && !INT) ie <= 1'b1;
        end
      endcase
    end
  end

  // The flag is a plain sync register; it must track EFx even while the bus is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ef_q <= 1'b0;
    else       ef_q <= EFx;
  end

endmodule

// File: tb/tb_pixie_dma_host.sv
// Bench for pixie_dma_host: machine-cycle reference model checked every clock,
// directed phases from the test plan plus a randomized phase.
module tb_pixie_dma_host;

  localparam int CT = 8;

  logic        clk, reset, clk_enable, DMAO, INT, EFx;
  logic [15:0] dma_base, mem_addr, r0;
  logic        mem_rd, ie, ef_q;
  logic [7:0]  mem_data, data_out;
  logic [1:0]  SC;
  logic [10:0] frame_bytes;

  pixie_dma_host #(.CYCLE_TICKS(CT)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .DMAO(DMAO), .INT(INT), .EFx(EFx),
    .dma_base(dma_base), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .SC(SC), .data_out(data_out), .r0(r0), .ie(ie), .ef_q(ef_q), .frame_bytes(frame_bytes)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int en_mode = 0;   // 0: always enabled, 1: one clock in three, 2: random
  int en_phase = 0;
  int rd_count = 0;
  int s3_count = 0;
  logic [1:0] prev_sc = 2'b00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return (a[7:0] + 8'h10) ^ a[15:8];
  endfunction

  // System memory: registered read, data held until the next read.
  initial mem_data = 8'h00;
  always @(posedge clk) if (mem_rd) mem_data <= mem_byte(mem_addr);

  // Reference model: one step per enabled clock, cycle decisions from the machine-cycle rules.
  int          m_sc, m_tick, m_cnt, m_frame;
  logic [15:0] m_r0;
  logic [7:0]  m_dout;
  logic        m_ie, m_ef;

  function automatic int next_sc(input int cur, input logic dmao, input logic intr, input logic iev);
    if (cur == 0) return 1;
    if (dmao) return 2;
    if (cur != 3 && intr && iev) return 3;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sc <= 0; m_tick <= 0; m_r0 <= 16'h0; m_ie <= 1'b1; m_dout <= 8'h0;
      m_cnt <= 0; m_frame <= 0; m_ef <= 1'b0;
    end else begin
      m_ef <= EFx;
      if (clk_enable) begin
        m_tick <= (m_tick + 1) % CT;
        if (m_sc == 2 && m_tick == 1) m_dout <= mem_byte(m_r0);
        if (m_sc == 3 && m_tick == 0) m_ie <= 1'b0;
        if (m_tick == CT - 1) begin
          m_sc <= next_sc(m_sc, DMAO, INT, m_ie);
          if (m_sc == 2) begin
            m_r0  <= m_r0 + 16'd1;
            m_cnt <= (m_cnt >= 2047) ? 2047 : m_cnt + 1;
          end
          if (m_sc == 3) begin
            m_r0 <= dma_base; m_frame <= m_cnt; m_cnt <= 0;
          end
          if ((m_sc == 0 || m_sc == 1) && !INT) m_ie <= 1'b1;
        end
      end
    end
  end

  // Compare process: all outputs against the model after every active edge.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      check("sc", 32'(SC), 32'(m_sc));
      check("r0", 32'(r0), 32'(m_r0));
      check("mem_addr", 32'(mem_addr), 32'(m_r0));
      check("mem_rd", 32'(mem_rd), 32'(m_sc == 2 && m_tick == 0 && clk_enable));
      check("ie", 32'(ie), 32'(m_ie));
      check("data_out", 32'(data_out), 32'(m_dout));
      check("frame_bytes", 32'(frame_bytes), 32'(m_frame));
      check("ef_q", 32'(ef_q), 32'(m_ef));
    end
  end

  always @(posedge clk) if (!reset && mem_rd) rd_count <= rd_count + 1;
  always @(negedge clk) begin
    if (SC == 2'b11 && prev_sc != 2'b11) s3_count <= s3_count + 1;
    prev_sc <= SC;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      EFx = 1'($urandom_range(0, 1));
      case (en_mode)
        0: clk_enable = 1'b1;
        1: begin clk_enable = (en_phase == 0); en_phase = (en_phase + 1) % 3; end
        default: clk_enable = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  task automatic wait_enter(input logic [1:0] s);
    int n = 0;
    while (SC == s && n < 300) begin tick(1); n++; end
    while (SC != s && n < 300) begin tick(1); n++; end
    if (n >= 300) begin
      n_tests++; n_fail++;
      $display("FAIL wait_enter: SC never reached %0d within 300 clocks", s);
    end
  endtask

  task automatic clocks_to_change(output int n);
    logic [1:0] s0 = SC;
    n = 0;
    while (SC == s0 && n < 300) begin tick(1); n++; end
  endtask

  initial begin
    int len;
    reset = 1'b1; clk_enable = 1'b1; DMAO = 1'b0; INT = 1'b0; EFx = 1'b0; dma_base = 16'h0;
    tick(3);
    check("rst_sc", 32'(SC), 32'h0);
    check("rst_r0", 32'(r0), 32'h0);
    check("rst_ie", 32'(ie), 32'h1);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_frame_bytes", 32'(frame_bytes), 32'h0);
    check("rst_ef_q", 32'(ef_q), 32'h0);
    reset = 1'b0;

    // Idle
    tick(40);
    check("idle_r0", 32'(r0), 32'h0);
    check("idle_no_reads", 32'(rd_count), 32'd0);

    // Line burst: 8 cycle ends with DMAO high, starting in S1
    wait_enter(2'b01);
    DMAO = 1'b1; tick(8 * CT); DMAO = 1'b0;
    tick(CT);
    check("burst_sc_back_to_s0", 32'(SC), 32'h0);
    check("burst_r0", 32'(r0), 32'd8);
    check("burst_last_byte", 32'(data_out), 32'h17);
    check("burst_reads", 32'(rd_count), 32'd8);

    // Interrupt held for two machine cycles
    dma_base = 16'h0900;
    wait_enter(2'b01);
    INT = 1'b1; tick(2 * CT);
    check("int_ie_cleared", 32'(ie), 32'h0);
    INT = 1'b0; tick(CT);
    check("int_ie_rearmed", 32'(ie), 32'h1);
    check("int_r0_base", 32'(r0), 32'h0900);
    check("int_frame_bytes", 32'(frame_bytes), 32'd8);
    check("int_one_s3", 32'(s3_count), 32'd1);

    // Priority: DMA first, interrupt once DMAO drops
    dma_base = 16'hFFFE;
    wait_enter(2'b01);
    DMAO = 1'b1; INT = 1'b1; tick(128 * CT); DMAO = 1'b0;
    tick(2 * CT);
    check("prio_frame_bytes", 32'(frame_bytes), 32'd128);
    check("prio_r0_base", 32'(r0), 32'hFFFE);
    check("prio_s3_count", 32'(s3_count), 32'd2);
    INT = 1'b0;

    // Pointer wrap
    wait_enter(2'b01);
    DMAO = 1'b1; tick(4 * CT); DMAO = 1'b0;
    tick(CT);
    check("wrap_r0", 32'(r0), 32'h0002);
    check("wrap_last_byte", 32'(data_out), 32'h11);

    // Byte-count saturation
    dma_base = 16'h1234;
    wait_enter(2'b01);
    DMAO = 1'b1; tick(2100 * CT); DMAO = 1'b0;
    tick(CT);
    wait_enter(2'b01);
    INT = 1'b1; tick(2 * CT); INT = 1'b0;
    check("sat_frame_bytes", 32'(frame_bytes), 32'd2047);
    check("sat_r0_base", 32'(r0), 32'h1234);
    check("sat_s3_count", 32'(s3_count), 32'd3);

    // Stall: one enabled clock in three
    en_mode = 1; en_phase = 0;
    wait_enter(2'b01);
    DMAO = 1'b1; tick(4 * 3 * CT); DMAO = 1'b0;
    tick(3 * CT);
    check("stall_r0", 32'(r0), 32'h1238);
    check("stall_last_byte", 32'(data_out), 32'h55);
    clocks_to_change(len);
    clocks_to_change(len);
    check("stall_cycle_len", 32'(len), 32'd24);

    // Reset at S2 tick 4
    en_mode = 0;
    wait_enter(2'b01);
    DMAO = 1'b1; tick(CT);
    check("pre_rst_sc", 32'(SC), 32'h2);
    tick(4);
    check("pre_rst_r0", 32'(r0), 32'h1238);
    reset = 1'b1; DMAO = 1'b0;
    #1;
    check("mid_rst_sc", 32'(SC), 32'h0);
    check("mid_rst_r0", 32'(r0), 32'h0);
    check("mid_rst_data_out", 32'(data_out), 32'h0);
    check("mid_rst_ie", 32'(ie), 32'h1);
    check("mid_rst_mem_rd", 32'(mem_rd), 32'h0);
    check("mid_rst_frame_bytes", 32'(frame_bytes), 32'h0);
    tick(3);
    reset = 1'b0;

    // Randomized traffic under random clock enables
    en_mode = 2;
    for (int seg = 0; seg < 100; seg++) begin
      DMAO     = 1'($urandom_range(0, 1));
      INT      = ($urandom_range(0, 3) == 0);
      dma_base = 16'($urandom);
      tick($urandom_range(4, 40));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixie_dma_host.md
# pixie_dma_host

CDP1802-side bus sequencer for the Pixie display interface. It drives the state code (SC) and the DMA data bus, and services the Pixie's DMA-out requests and frame interrupts. It steps through machine cycles (fetch, execute, DMA, interrupt) and fetches display bytes from system memory at the R0 pointer. On each frame interrupt it reloads R0 from a programmable base address. It sits between system memory and the Pixie data path, which is the DMA requester. It also serves as the standalone host model in video-only builds and benches.

## Interface
- CYCLE_TICKS, 8: enabled clocks per machine cycle, ≥4.
- clk  in  1  bus clock; all logic is in this domain.
- reset  in  1  asynchronous, active-high.
- clk_enable  in  1  advance qualifier; one enabled clock is one tick.
- DMAO  in  1  DMA-out request from the Pixie.
- INT  in  1  frame interrupt request from the Pixie.
- EFx  in  1  Pixie flag; registered to ef_q for software visibility only.
- dma_base  in  16  value loaded into R0 on each interrupt cycle.
- mem_addr  out  16  memory read address; always equals r0.
- mem_rd  out  1  read strobe, one clk wide.
- mem_data  in  8  read data; valid on the clk after mem_rd.
- SC  out  2  state code: 00 S0 fetch, 01 S1 execute, 10 S2 DMA, 11 S3 interrupt.
- data_out  out  8  DMA byte presented to the Pixie.
- r0  out  16  DMA pointer.
- ie  out  1  interrupt enable.
- ef_q  out  1  registered EFx.
- frame_bytes  out  11  number of DMA bytes in the previous frame, saturating.

## Operation
- tick_cnt counts 0..CYCLE_TICKS-1 on enabled clocks and wraps. A machine cycle ends on the tick where tick_cnt = CYCLE_TICKS-1.
- State machine on SC, evaluated only at cycle end:
  - From S0: go to S1.
  - From S1: DMAO → S2; else INT & ie → S3; else S0.
  - From S2: DMAO → S2; else INT & ie → S3; else S0.
  - From S3: DMAO → S2; else S0.
- DMA has priority over interrupt whenever both are pending.
- S2 cycle:
  - tick 0: mem_rd=1 at address r0.
  - tick 1: data_out ← mem_data.
  - Last tick: r0 ← r0+1, with modulo-2^16 wrap (0xFFFF → 0x0000); byte_cnt increments, saturating at 2047.
- S3 cycle:
  - Tick 0: ie ← 0.
  - Last tick: r0 ← dma_base, frame_bytes ← byte_cnt, byte_cnt ← 0.
- ie returns to 1 at the end of any S0 or S1 cycle in which INT is sampled low. This gives one S3 per INT assertion.
- data_out holds its last value outside S2.
- mem_rd is 0 everywhere except S2 tick 0.
- ef_q ← EFx on every clk; it is not gated by clk_enable.
- No state changes while clk_enable=0. mem_rd is also qualified by clk_enable.

## Timing
- Reset values:
  - SC=00, tick_cnt=0, r0=0x0000, ie=1, data_out=0x00.
  - mem_rd=0, frame_bytes=0, byte_cnt=0, ef_q=0.
- Reset is asynchronous and may occur mid-cycle. It aborts any S2 without incrementing r0 and without counting the byte.
- After reset, the first enabled clock is tick 0 of S0.
- Request sampling: DMAO and INT are sampled only on the cycle-end tick. Pulses that fall entirely between cycle ends are ignored.
- Read latency: mem_rd at S2 tick 0; data_out is valid from tick 2 through the last tick of the same cycle, and remains stable until the next S2 tick 1.
- A DMAO held for N consecutive cycle ends produces N back-to-back S2 cycles, N bytes, and r0 += N.
- Throughput: one byte per CYCLE_TICKS ticks.
- SC changes only on the clk following a cycle-end tick.

## Test plan
- Idle: DMAO=INT=0 after reset, CYCLE_TICKS=8 → SC alternates 00/01 every 8 ticks; mem_rd never asserts; r0 stays 0.
- Line burst: memory holds 0x10+i at address i; DMAO held for 8 cycle ends starting in S1 → 8 consecutive S2 cycles; data_out sequence 0x10..0x17; r0=8; then SC=00.
- Interrupt: dma_base=0x0900, INT high for 2 machine cycles → exactly one S3; r0=0x0900 at its end; ie=0 until the first S0/S1 cycle end with INT low, then 1.
- Priority: DMAO and INT both high at the end of S1 → S2 first, S3 after DMAO drops; frame_bytes then equals the number of bytes in the preceding frame, e.g. 128 after 128 S2 cycles.
- Wrap and saturation: r0 preset via interrupt with dma_base=0xFFFE, 4 DMA bytes → r0=0x0002; 2100 DMA bytes between interrupts → frame_bytes=2047.
- Stall and reset: clk_enable toggled 1-in-3 → cycle lengths scale ×3 and the byte sequence is unchanged. Reset asserted at S2 tick 4 → outputs immediately return to their reset values and r0 is not incremented.
